// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin drain arbiter: grants one non-empty FWFT FIFO at a time for a
// burst of up to BURST_LEN words, pops it directly, and forwards each word
// through a single registered valid/ready stage tagged with its source port.
//
// state   | meaning
// S_IDLE  | searching from rr_ptr for the next non-empty port, no pops
// S_BURST | draining the granted port while the output stage can accept
module fifo_rr_drain_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int BURST_LEN     = 8,
  parameter int PORT_ID_WIDTH = 2
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [NUM_PORTS-1:0]            i_fifo_empty,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_fifo_data_in,
  output logic [NUM_PORTS-1:0]            o_fifo_pop,
  output logic [DATA_WIDTH-1:0]           o_data_out,
  output logic                            o_data_valid,
  input  logic                            i_data_ready,
  output logic [PORT_ID_WIDTH-1:0]        o_data_src,
  output logic                            o_busy
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [PORT_ID_WIDTH:0] NP_W = (PORT_ID_WIDTH + 1)'(NUM_PORTS);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                   r_state;
  logic [PORT_ID_WIDTH-1:0] r_grant;
  logic [PORT_ID_WIDTH-1:0] r_rr_ptr;
  logic [CNT_W-1:0]         r_burst_cnt;
  logic [DATA_WIDTH-1:0]    r_data_out;
  logic                     r_data_valid;
  logic [PORT_ID_WIDTH-1:0] r_data_src;

  logic                     w_found;
  logic [PORT_ID_WIDTH-1:0] w_sel;
  logic [PORT_ID_WIDTH:0]   w_sum;
  logic                     w_grant_empty;
  logic [DATA_WIDTH-1:0]    w_grant_data;
  logic                     w_stage_free;
  logic                     w_pop;
  logic                     w_last_word;
  logic [PORT_ID_WIDTH-1:0] w_grant_next;

  // Round-robin search: first non-empty port starting at rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (PORT_ID_WIDTH + 1)'(k);
      if (w_sum >= NP_W) begin
        w_sum = w_sum - NP_W;
      end
      if (!w_found && !i_fifo_empty[w_sum[PORT_ID_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_sum[PORT_ID_WIDTH-1:0];
      end
    end
  end

  // Mux out the granted port's empty flag and head word.
  always_comb begin
    w_grant_empty = 1'b1;
    w_grant_data  = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (r_grant == PORT_ID_WIDTH'(j)) begin
        w_grant_empty = i_fifo_empty[j];
        w_grant_data  = i_fifo_data_in[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_stage_free = !r_data_valid || i_data_ready;
  // Reset gating keeps a mid-burst reset from popping a word that would be lost.
  assign w_pop        = (r_state == S_BURST) && !w_grant_empty && w_stage_free && !i_reset;
  assign w_last_word  = (r_burst_cnt == CNT_W'(BURST_LEN - 1));
  assign w_grant_next = (r_grant == PORT_ID_WIDTH'(NUM_PORTS - 1)) ? '0
                                                                   : r_grant + PORT_ID_WIDTH'(1);

  // Pop decode: only the granted port, only when its word can be taken.
  always_comb begin
    o_fifo_pop = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      o_fifo_pop[j] = w_pop && (r_grant == PORT_ID_WIDTH'(j));
    end
  end

  // Grant FSM, burst counter and the registered output stage.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_rr_ptr     <= '0;
      r_burst_cnt  <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_data_src   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant     <= w_sel;
            r_burst_cnt <= '0;
            r_state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_pop) begin
            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
          end
          if ((w_pop && w_last_word) || w_grant_empty) begin
            r_rr_ptr <= w_grant_next;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_pop) begin
        r_data_out   <= w_grant_data;
        r_data_src   <= r_grant;
        r_data_valid <= 1'b1;
      end else if (i_data_ready) begin
        r_data_valid <= 1'b0;
      end
    end
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_data_src   = r_data_src;
  assign o_busy       = (r_state == S_BURST) || r_data_valid;

endmodule
